// File: rtl/blockram_pkg.sv
// Shared widths and reader FSM encoding for blockram and its clients.
package blockram_pkg;

   function automatic int unsigned addr_width(input int unsigned depth);
      return 12 + depth;
   endfunction

   function automatic int unsigned data_width(input int unsigned width);
      return 8 << width;
   endfunction

   // One extra bit so a full-memory count (2^AW) fits.
   function automatic int unsigned count_width(input int unsigned depth);
      return 13 + depth;
   endfunction

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } rd_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; the head entry is presented combinationally.
module stream_fifo2 #(
   parameter int unsigned PW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [PW-1:0] push_data,
   input  logic          pop,
   output logic [PW-1:0] pop_data,
   output logic          valid,
   output logic [1:0]    count
);

   logic [PW-1:0] mem_q [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   logic          pop_ok;

   assign valid    = (count_q != 2'd0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign pop_ok   = pop & valid;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/blockram_reader.sv
// Streams a contiguous blockram address range out as a valid/ready stream,
// hiding the one-cycle read latency behind a two-entry FIFO.
module blockram_reader
   import blockram_pkg::*;
#(
   parameter int unsigned WIDTH = 0,
   parameter int unsigned DEPTH = 1,
   localparam int unsigned AW = addr_width(DEPTH),
   localparam int unsigned DW = data_width(WIDTH),
   localparam int unsigned CW = count_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [CW-1:0] count,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rval,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last
);

   rd_state_e     state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] issue_left_q, issue_left_d;
   logic          inflight_q, inflight_d;
   logic          inflight_last_q, inflight_last_d;
   logic          done_q, done_d;
   logic          pop, issue, last_issue;
   logic [1:0]    fifo_count;
   logic [2:0]    occupancy;
   logic [DW:0]   head;

   assign pop        = out_valid & out_ready;
   // Words already committed to the FIFO, counting the read still in flight.
   assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign issue      = (state_q == StRun) && (occupancy < (3'd2 + {2'b00, pop}));
   assign last_issue = issue && (issue_left_q == CW'(1));

   assign raddr    = addr_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign out_last = head[DW];
   assign out_data = head[DW-1:0];

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      issue_left_d    = issue_left_q;
      inflight_d      = issue;
      inflight_last_d = last_issue;
      done_d          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = StRun;
                  addr_d       = base_addr;
                  issue_left_d = count;
               end
            end
         end
         StRun: begin
            if (issue) begin
               addr_d       = addr_q + AW'(1);
               issue_left_d = issue_left_q - CW'(1);
            end
            if (last_issue) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && out_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         issue_left_q    <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         issue_left_q    <= issue_left_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   stream_fifo2 #(
      .PW (DW + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, rval}),
      .pop       (pop),
      .pop_data  (head),
      .valid     (out_valid),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_blockram_reader.sv
// Randomised bench for blockram_reader against a queue-based model of the beat stream.
module tb_blockram_reader;

   localparam int AW = 13;
   localparam int DW = 8;
   localparam int CW = 14;
   localparam int MEMSZ = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] count = '0;
   logic          busy, done, out_valid, out_last;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rval, out_data;
   logic          out_ready = 1'b0;

   logic [DW-1:0] mem [MEMSZ];

   int total = 0;
   int passed = 0;
   int nfail = 0;

   // Model state
   logic [8:0]    expq [$];
   bit            active = 0;
   bit            exp_done = 0;
   bit            nxt_active, nxt_done, acc;
   int            issued = 0, consumed = 0, cycle = 0, acc_cycle = 0;
   int            done_total = 0, last_cnt = 0, done_rel = 0;
   logic [AW-1:0] cmd_base = '0;
   logic [AW-1:0] prev_raddr = '0;
   logic [AW-1:0] exp_addr;
   bit            stall_prev = 0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic [8:0]    e;
   logic [DW-1:0] log_data [$];
   int            log_cyc [$];
   logic [AW-1:0] log_addr [$];
   int            ready_mode = 0;
   int            tog_ph = 0;

   blockram_reader #(
      .WIDTH (0),
      .DEPTH (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .raddr     (raddr),
      .rval      (rval),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Blockram read port: one-cycle latency.
   always @(posedge clk) rval <= mem[raddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         nfail++;
         if (nfail <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (tog_ph == 0) || (tog_ph == 3);
               tog_ph = (tog_ph + 1) % 4;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_last", out_last, 0);
         chk("rst_raddr", raddr, 0);
         chk("rst_data", out_data, 0);
         expq.delete();
         active = 0;
         exp_done = 0;
         stall_prev = 0;
         prev_raddr = raddr;
      end else begin
         nxt_active = active;
         nxt_done = 0;
         acc = start && !busy;
         chk("busy", busy, active);
         chk("done", done, exp_done);
         if (done) begin
            done_total++;
            done_rel = cycle - acc_cycle;
         end
         if (!active) chk("idle_valid", out_valid, 0);
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         chk("no_overflow",
             dut.inflight_q && dut.fifo_count == 2'd2 && !(out_valid && out_ready), 0);
         if (active) begin
            if (raddr != prev_raddr) begin
               issued++;
               log_addr.push_back(prev_raddr);
            end
            exp_addr = cmd_base + AW'(issued);
            chk("raddr", raddr, exp_addr);
            chk("outstanding", (issued - consumed) <= 2, 1);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("beat_data", out_data, e[7:0]);
               chk("beat_last", out_last, e[8]);
               if (ready_mode == 0) chk("beat_cycle", cycle - acc_cycle, 3 + consumed);
               log_data.push_back(out_data);
               log_cyc.push_back(cycle - acc_cycle);
               if (out_last) last_cnt++;
               consumed++;
               if (e[8]) begin
                  nxt_active = 0;
                  nxt_done = 1;
               end
            end
         end
         if (acc) begin
            acc_cycle = cycle;
            cmd_base = base_addr;
            issued = 0;
            consumed = 0;
            last_cnt = 0;
            log_data.delete();
            log_cyc.delete();
            log_addr.delete();
            if (count == '0) begin
               nxt_done = 1;
            end else begin
               nxt_active = 1;
               for (int i = 0; i < int'(count); i++)
                  expq.push_back({i == int'(count) - 1, mem[(int'(base_addr) + i) % MEMSZ]});
            end
         end
         active = nxt_active;
         exp_done = nxt_done;
         stall_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
         prev_raddr = acc ? base_addr : raddr;
      end
   end

   task automatic wait_done(input int budget);
      int n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      chk("done_timeout", n < budget, 1);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after done.
   task automatic run_cmd(input logic [AW-1:0] b, input logic [CW-1:0] c, input int mode);
      ready_mode = mode;
      base_addr = b;
      count = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(4 * int'(c) + 60);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int dtot;
      logic [AW-1:0] rb;
      logic [CW-1:0] rc;
      for (int i = 0; i < MEMSZ; i++) mem[i] = i[7:0];
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic command, ready always high
      run_cmd(13'h010, 14'd4, 0);
      chk("t1_size", log_data.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_data", log_data[i], 32'h10 + i);
      chk("t1_first_cyc", log_cyc[0], 3);
      chk("t1_last_cyc", log_cyc[3], 6);
      chk("t1_done_cyc", done_rel, 7);
      chk("t1_lasts", last_cnt, 1);

      // Toggling backpressure
      run_cmd(13'h010, 14'd4, 1);
      chk("t2_size", log_data.size(), 4);
      for (int i = 0; i < 4; i++) chk("t2_data", log_data[i], 32'h10 + i);
      chk("t2_lasts", last_cnt, 1);

      // Address wrap
      run_cmd(13'h1FFE, 14'd4, 0);
      chk("t3_a0", log_addr[0], 32'h1FFE);
      chk("t3_a1", log_addr[1], 32'h1FFF);
      chk("t3_a2", log_addr[2], 32'h0000);
      chk("t3_a3", log_addr[3], 32'h0001);
      chk("t3_d0", log_data[0], 32'hFE);
      chk("t3_d1", log_data[1], 32'hFF);
      chk("t3_d2", log_data[2], 32'h00);
      chk("t3_d3", log_data[3], 32'h01);

      // Zero-length command
      run_cmd(13'h123, 14'd0, 0);
      chk("t4_done_cyc", done_rel, 1);
      chk("t4_size", log_data.size(), 0);

      // Start while busy is ignored
      ready_mode = 0;
      base_addr = 13'h010;
      count = 14'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      base_addr = 13'h100;
      count = 14'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(80);
      @(posedge clk);
      #1;
      chk("t5_size", log_data.size(), 4);
      for (int i = 0; i < 4; i++) chk("t5_data", log_data[i], 32'h10 + i);

      // New start accepted in the done cycle
      base_addr = 13'h020;
      count = 14'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      base_addr = 13'h040;
      count = 14'd2;
      wait_done(80);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(80);
      @(posedge clk);
      #1;
      chk("t6_size", log_data.size(), 2);
      chk("t6_d0", log_data[0], 32'h40);
      chk("t6_d1", log_data[1], 32'h41);
      chk("t6_first_cyc", log_cyc[0], 3);
      chk("t6_done_cyc", done_rel, 5);

      // Reset after the second beat
      base_addr = 13'h010;
      count = 14'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (log_data.size() < 2 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("t7_beat2_seen", log_data.size() >= 2, 1);
      #1 rst_n = 1'b0;
      dtot = done_total;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("t7_no_done", done_total, dtot);

      // Random commands over random memory contents
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 1)
            for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
         rb = 13'($urandom);
         rc = 14'($urandom_range(1, 40));
         run_cmd(rb, rc, int'($urandom_range(1, 2)));
         chk("rand_size", log_data.size(), 32'(rc));
         chk("rand_lasts", last_cnt, 1);
      end

      // Whole memory with random backpressure
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
      dtot = done_total;
      run_cmd(13'($urandom), 14'd8192, 2);
      chk("full_size", log_data.size(), 8192);
      chk("full_lasts", last_cnt, 1);
      chk("full_dones", done_total, dtot + 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
